// File: rtl/psum_spad_pkg.sv
// Purpose : shared op-code constants and clear-sequencer state encoding for psum_spad_acc.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package psum_spad_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_WR  = 2'b10;
    localparam logic [1:0] OP_ACC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_CLEAR = 2'd2
    } state_e;

endpackage

// File: rtl/psum_sat_add.sv
// Purpose : signed W+W adder with overflow flag; clamps instead of wrapping when PSUM_SPAD_SAT_EN is defined.
// Latency : combinational.
// Backpressure: none.
// Ports   : a, b (addends), sum (W-bit result), ovf (true signed overflow of W bits).
module psum_sat_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         ovf
);

    logic [W:0] wide;

    // One guard bit: the signed result fits in W+1 bits, so overflow of W
    // bits shows up as the top two bits disagreeing.
    assign wide = {a[W-1], a} + {b[W-1], b};
    assign ovf  = wide[W] ^ wide[W-1];

`ifdef PSUM_SPAD_SAT_EN
    // wide[W] is the true sign of the unbounded result.
    assign sum = !ovf    ? wide[W-1:0] :
                 wide[W] ? {1'b1, {(W-1){1'b0}}} :
                           {1'b0, {(W-1){1'b1}}};
`else
    assign sum = wide[W-1:0];
`endif

endmodule

// File: rtl/psum_spad_acc.sv
// Purpose : partial-sum scratchpad with RD / WR / in-place ACC and a clear sequencer (optional ACC saturation via PSUM_SPAD_SAT_EN).
// Latency : op accepted in cycle N executes in N+1; RD result (rd_valid pulse) in N+2; one op per cycle.
// Backpressure: op_ready low during reset, while clearing (DRAIN/CLEAR) and in a cycle where clr_start is raised.
// Ports   : clk, rst (sync, active high); op_valid/op_ready/op_code/addr/data_in op channel;
//           rd_valid/rd_data read return; clr_start request, busy status; ovf sticky ACC overflow.
module psum_spad_acc
    import psum_spad_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [1:0]        op_code,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              clr_start,
    output logic              busy,
    output logic              ovf
);

    localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              s1_vld_q, s1_vld_d;
    logic [1:0]        s1_op_q, s1_op_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
    logic [DATA_W-1:0] s1_data_q, s1_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              ready_int;
    logic              accept;
    logic              s1_in_range;
    logic [DATA_W-1:0] s1_rdata;
    logic [DATA_W-1:0] acc_sum;
    logic              acc_ovf;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    // Only reachable when DEPTH is not a power of two.
    assign s1_in_range = {1'b0, s1_addr_q} < DEPTH_X;
    // Stage-1 reads the array directly; a write from the previous op has
    // already landed, so back-to-back ops need no forwarding.
    assign s1_rdata    = s1_in_range ? mem_q[s1_addr_q] : '0;

    psum_sat_add #(.W(DATA_W)) u_sat_add (
        .a   (s1_rdata),
        .b   (s1_data_q),
        .sum (acc_sum),
        .ovf (acc_ovf)
    );

    assign ready_int = (state_q == ST_IDLE) && !clr_start;
    assign accept    = op_valid && ready_int && (op_code != OP_NOP);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        s1_vld_d   = accept;
        s1_op_d    = s1_op_q;
        s1_addr_d  = s1_addr_q;
        s1_data_d  = s1_data_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        ovf_d      = ovf_q;
        mem_we     = 1'b0;
        mem_waddr  = s1_addr_q;
        mem_wdata  = s1_data_q;

        if (accept) begin
            s1_op_d   = op_code;
            s1_addr_d = addr;
            s1_data_d = data_in;
        end

        if (s1_vld_q) begin
            case (s1_op_q)
                OP_RD: begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = s1_rdata;
                end
                OP_WR: mem_we = s1_in_range;
                OP_ACC: begin
                    mem_we    = s1_in_range;
                    mem_wdata = acc_sum;
                    if (s1_in_range && acc_ovf) begin
                        ovf_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        // The stage-1 op always retires in the clr_start cycle, so DRAIN
        // leaves stage 1 empty and CLEAR never competes for the write port.
        case (state_q)
            ST_IDLE: begin
                if (clr_start) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = ST_CLEAR;
                cnt_d   = '0;
            end
            ST_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = '0;
                if (cnt_q == LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: state_d = ST_CLEAR;
        endcase

        // An op in flight when reset hits is discarded.
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            s1_vld_q   <= 1'b0;
            s1_op_q    <= OP_NOP;
            s1_addr_q  <= '0;
            s1_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s1_vld_q   <= s1_vld_d;
            s1_op_q    <= s1_op_d;
            s1_addr_q  <= s1_addr_d;
            s1_data_q  <= s1_data_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            ovf_q      <= ovf_d;
        end
    end

    // Array is not reset; the clear sequencer zeroes it after every reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // Outputs show their reset values for the whole time rst is high,
    // including the first cycle of a mid-operation reset.
    assign op_ready = !rst && ready_int;
    assign busy     = rst || (state_q != ST_IDLE);
    assign rd_valid = !rst && rd_valid_q;
    assign rd_data  = rst ? '0 : rd_data_q;
    assign ovf      = !rst && ovf_q;

endmodule

// File: tb/tb_psum_spad_acc.sv
// Purpose : self-checking bench for psum_spad_acc; one DEPTH=64 and one DEPTH=48 instance share stimulus.
// Latency : reference model predicts outputs cycle by cycle; outputs compared on every falling edge.
// Backpressure: model tracks when each instance accepts ops from its own busy/clear timeline.
module tb_psum_spad_acc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [1:0]  op_code = 2'b00;
    logic [5:0]  addr = '0;
    logic [15:0] data_in = '0;
    logic        clr_start = 1'b0;

    logic        op_ready0, rd_valid0, busy0, ovf0;
    logic [15:0] rd_data0;
    logic        op_ready1, rd_valid1, busy1, ovf1;
    logic [15:0] rd_data1;

    always #5 clk = ~clk;

    psum_spad_acc #(.DATA_W(16), .DEPTH(64)) dut0 (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready0),
        .op_code(op_code), .addr(addr), .data_in(data_in),
        .rd_valid(rd_valid0), .rd_data(rd_data0), .clr_start(clr_start),
        .busy(busy0), .ovf(ovf0)
    );

    psum_spad_acc #(.DATA_W(16), .DEPTH(48)) dut1 (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready1),
        .op_code(op_code), .addr(addr), .data_in(data_in),
        .rd_valid(rd_valid1), .rd_data(rd_data1), .clr_start(clr_start),
        .busy(busy1), .ovf(ovf1)
    );

    int n_err = 0;
    int n_chk = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // busy_m: cycles of busy still to come (0 = idle). A pending op is the
    // op accepted last cycle; it takes effect at the next edge.
    logic [15:0] mem_m [2][64];
    int          busy_m [2] = '{64, 48};
    bit          pv [2];
    logic [1:0]  pop [2];
    int          pa [2];
    logic [15:0] pd [2];
    bit          erv [2];
    logic [15:0] erd [2];
    bit          eov [2];
    int          m_dep;
    int          m_sum;
    logic [15:0] m_res;
    bit          m_idle;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_dep = (k == 0) ? 64 : 48;
            if (rst) begin
                busy_m[k] = m_dep;
                pv[k]     = 1'b0;
                erv[k]    = 1'b0;
                erd[k]    = 16'h0;
                eov[k]    = 1'b0;
                for (int j = 0; j < 64; j++) mem_m[k][j] = 16'h0;
            end else begin
                m_idle = (busy_m[k] == 0);
                erv[k] = 1'b0;
                if (pv[k]) begin
                    case (pop[k])
                        2'b01: begin
                            erv[k] = 1'b1;
                            erd[k] = (pa[k] < m_dep) ? mem_m[k][pa[k]] : 16'h0;
                        end
                        2'b10: if (pa[k] < m_dep) mem_m[k][pa[k]] = pd[k];
                        2'b11: if (pa[k] < m_dep) begin
                            m_sum = int'($signed(mem_m[k][pa[k]])) + int'($signed(pd[k]));
                            if (m_sum > 32767 || m_sum < -32768) begin
                                eov[k] = 1'b1;
`ifdef PSUM_SPAD_SAT_EN
                                m_res = (m_sum > 0) ? 16'h7FFF : 16'h8000;
`else
                                m_res = m_sum[15:0];
`endif
                            end else begin
                                m_res = m_sum[15:0];
                            end
                            mem_m[k][pa[k]] = m_res;
                        end
                        default: ;
                    endcase
                end
                pv[k] = m_idle && !clr_start && op_valid && (op_code != 2'b00);
                if (pv[k]) begin
                    pop[k] = op_code;
                    pa[k]  = int'(addr);
                    pd[k]  = data_in;
                end
                if (busy_m[k] > 0) begin
                    busy_m[k] = busy_m[k] - 1;
                end else if (clr_start) begin
                    busy_m[k] = m_dep + 1;
                    for (int j = 0; j < 64; j++) mem_m[k][j] = 16'h0;
                end
            end
        end
    end

    task automatic cmp_dut(input int k, input logic rdy, input logic rv,
                           input logic [15:0] rd, input logic bsy, input logic ov);
        string p;
        p = (k == 0) ? "d64" : "d48";
        check({p, ".busy"},     32'(bsy), 32'(rst || busy_m[k] > 0));
        check({p, ".op_ready"}, 32'(rdy), 32'(!rst && busy_m[k] == 0 && !clr_start));
        check({p, ".rd_valid"}, 32'(rv),  32'(!rst && erv[k]));
        check({p, ".rd_data"},  32'(rd),  32'(rst ? 16'h0 : erd[k]));
        check({p, ".ovf"},      32'(ov),  32'(!rst && eov[k]));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_dut(0, op_ready0, rd_valid0, rd_data0, busy0, ovf0);
            cmp_dut(1, op_ready1, rd_valid1, rd_data1, busy1, ovf1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [1:0] c, input int a, input logic [15:0] d);
        op_valid = 1'b1;
        op_code  = c;
        addr     = 6'(a);
        data_in  = d;
        step();
        op_valid = 1'b0;
        op_code  = 2'b00;
    endtask

    // Counts busy cycles from the current cycle until both instances idle.
    task automatic count_busy(input string nm, input int e0, input int e1);
        int n0, n1;
        n0 = 0;
        n1 = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy0 && !busy1) break;
            n0 += int'(busy0);
            n1 += int'(busy1);
        end
        check({nm, ".busy64"}, 32'(n0), 32'(e0));
        check({nm, ".busy48"}, 32'(n1), 32'(e1));
    endtask

    task automatic rd_check(input string nm, input int a, input logic [15:0] e0, input logic [15:0] e1);
        op(2'b01, a, 16'h0);
        @(negedge clk);
        check({nm, ".rv_n1"}, 32'(rd_valid0), 32'd0);
        step();
        @(negedge clk);
        check({nm, ".rv_n2"}, 32'(rd_valid0), 32'd1);
        check({nm, ".rd64"}, 32'(rd_data0), 32'(e0));
        check({nm, ".rd48"}, 32'(rd_data1), 32'(e1));
        step();
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        count_busy(nm, 64, 48);
        check({nm, ".ovf"}, 32'(ovf0), 32'd0);
        step();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        step();
        chk_en = 1'b1;
        step();

        // Power-up clear, then read every address.
        do_reset("reset");
        rd_check("rd_first", 0, 16'h0, 16'h0);
        for (int i = 0; i < 64; i++) op(2'b01, i, 16'h0);
        repeat (3) step();

        // WR then two ACCs then RD, all back to back.
        op(2'b10, 5, 16'h0010);
        op(2'b11, 5, 16'h0003);
        op(2'b11, 5, 16'hFFFF);
        rd_check("acc_chain", 5, 16'h0012, 16'h0012);

        // Positive overflow.
        op(2'b10, 9, 16'h7FFF);
        op(2'b11, 9, 16'h0001);
`ifdef PSUM_SPAD_SAT_EN
        rd_check("acc_ovf", 9, 16'h7FFF, 16'h7FFF);
`else
        rd_check("acc_ovf", 9, 16'h8000, 16'h8000);
`endif
        check("acc_ovf.flag", 32'(ovf0), 32'd1);

        // clr_start vs op in the same cycle, with an ACC in stage 1.
        do_reset("reset2");
        op(2'b10, 0, 16'h7FFF);
        op(2'b11, 0, 16'h0001);
        clr_start = 1'b1;
        op_valid  = 1'b1;
        op_code   = 2'b10;
        addr      = 6'd0;
        data_in   = 16'h0005;
        @(negedge clk);
        check("clr_vs_op.ready", 32'(op_ready0), 32'd0);
        step();
        clr_start = 1'b0;
        op_valid  = 1'b0;
        op_code   = 2'b00;
        count_busy("clr_drain", 65, 49);
        check("clr_drain.acc_done", 32'(ovf0), 32'd1);
        step();
        rd_check("clr_a0", 0, 16'h0, 16'h0);

        // Reset ten cycles into a clear.
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        repeat (11) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy("rst_mid_clear", 64, 48);
        check("rst_mid_clear.ovf", 32'(ovf0), 32'd0);
        step();

        // Reset with a WR in stage 1.
        op(2'b10, 3, 16'h0099);
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy("rst_wr", 64, 48);
        step();
        rd_check("rst_wr", 3, 16'h0, 16'h0);

        // Out-of-range on the 48-entry instance.
        op(2'b10, 47, 16'h1234);
        op(2'b10, 50, 16'h0007);
        op(2'b11, 50, 16'h0001);
        rd_check("oor_a50", 50, 16'h0008, 16'h0);
        rd_check("oor_a47", 47, 16'h1234, 16'h1234);

        // Randomized traffic; the compare process does the checking.
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 999) == 0);
            clr_start = ($urandom_range(0, 149) == 0);
            op_valid  = ($urandom_range(0, 3) != 0);
            op_code   = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       addr = 6'($urandom_range(0, 3));
                1:       addr = 6'($urandom_range(46, 49));
                default: addr = 6'($urandom_range(0, 63));
            endcase
            case ($urandom_range(0, 7))
                0:       data_in = 16'h7FFF;
                1:       data_in = 16'h8000;
                2:       data_in = 16'h0001;
                3:       data_in = 16'hFFFF;
                default: data_in = 16'($urandom);
            endcase
            step();
        end
        rst       = 1'b0;
        clr_start = 1'b0;
        op_valid  = 1'b0;
        op_code   = 2'b00;
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
